// File: rtl/punc_mem_port_pkg.sv
// Shared PUnC memory-port definitions: FSM state encodings and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package punc_mem_port_pkg;

    localparam int PUNC_ADDR_W = 16;
    localparam int PUNC_DATA_W = 16;

    typedef enum logic [1:0] {
        PUNC_MEM_IDLE = 2'd0,
        PUNC_MEM_BUSY = 2'd1,
        PUNC_MEM_RESP = 2'd2
    } punc_mem_state_t;

endpackage

// File: rtl/punc_mem_timeout.sv
// BUSY-cycle watchdog: counts cycles while enabled, flags the LIMIT-th one.
// Latency: expired is combinational from the count, high during the LIMIT-th enabled cycle.
// Backpressure: none; clr has priority over en.
module punc_mem_timeout #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles since the last clear; value is (cycle index - 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/punc_mem_port.sv
// Single-outstanding PUnC memory port: holds one request on the bus until mem_ack, then pulses a response.
// Latency: accept at edge N, BUSY from N+1, ack in N+k gives resp_valid in N+k+1, req_ready again in N+k+2.
// Backpressure: req_ready low in BUSY/RESP; requests there are ignored. Optional watchdog: PUNC_MEM_TIMEOUT_EN.
module punc_mem_port
    import punc_mem_port_pkg::*;
#(
    parameter int ADDR_W         = PUNC_ADDR_W,
    parameter int DATA_W         = PUNC_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    punc_mem_state_t state_q, state_d;
    logic            we_q;
    logic            busy;
    logic            accept;
    logic            expired;

    assign busy   = (state_q == PUNC_MEM_BUSY);
    assign accept = (state_q == PUNC_MEM_IDLE) && req_valid;

`ifdef PUNC_MEM_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic err_q;

    // Counter restarts whenever we are outside BUSY, so entering BUSY sees zero.
    punc_mem_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .en      (busy),
        .expired (expired)
    );

    // Error flag: set only when the watchdog fires without a simultaneous ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (busy && !mem_ack && expired) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    assign expired  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PUNC_MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ack beats a same-cycle timeout; RESP lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PUNC_MEM_IDLE: if (req_valid)          state_d = PUNC_MEM_BUSY;
            PUNC_MEM_BUSY: if (mem_ack || expired) state_d = PUNC_MEM_RESP;
            PUNC_MEM_RESP:                         state_d = PUNC_MEM_IDLE;
            default:                               state_d = PUNC_MEM_IDLE;
        endcase
    end

    // Capture the request at accept; it stays frozen for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            we_q      <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
        end
    end

    // Response data: reads load mem_rdata on ack, writes keep the old value, timeout zeroes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
        end else if (busy && mem_ack) begin
            if (!we_q) begin
                resp_rdata <= mem_rdata;
            end
        end else if (busy && expired) begin
            resp_rdata <= '0;
        end
    end

    assign req_ready  = (state_q == PUNC_MEM_IDLE);
    assign resp_valid = (state_q == PUNC_MEM_RESP);
    assign mem_en     = busy;
    assign mem_we     = busy && we_q;

endmodule

// File: tb/tb_punc_mem_port.sv
module tb_punc_mem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the response data word the port should currently hold.
    logic [15:0] model_rdata;

    always #5 clk = ~clk;

    punc_mem_port #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One access. Inputs are driven and outputs sampled on the falling edge.
    // The memory acks in the k-th BUSY cycle (k larger than the BUSY time means no ack).
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int k, input logic [15:0] mrd,
                          output logic [15:0] got_rdata, output logic got_err, output int en_cycles);
        bit addr_ok = 1'b1;
        en_cycles = 0;
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!mem_en) break;
            en_cycles++;
            if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) addr_ok = 1'b0;
            if (req_ready !== 1'b0) addr_ok = 1'b0;
            // Scramble the request inputs: the captured copy must not follow them.
            req_we    = ~we;
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            mem_ack   = (en_cycles == k);
            mem_rdata = (en_cycles == k) ? mrd : 16'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("bus_stable_in_busy", {31'b0, addr_ok}, 32'd1);
        chk("resp_valid_pulse", {31'b0, resp_valid}, 32'd1);
        chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
        got_rdata = resp_rdata;
        got_err   = resp_err;
        @(negedge clk);
        chk("resp_valid_one_cycle", {31'b0, resp_valid}, 32'd0);
        chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          k;
        logic [15:0] mrd;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_en;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] got_d;
    logic        got_e;
    int          got_n;

    initial begin
        // Directed vectors: expected resp_rdata for writes is the previous read's data.
        vecs[0] = '{1'b0, 16'h3000, 16'h0000, 3, 16'h1234, 16'h1234, 1'b0, 3};
        vecs[1] = '{1'b1, 16'h4001, 16'hBEEF, 1, 16'h9999, 16'h1234, 1'b0, 1};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h5555, 2, 16'h0A5A, 16'h0A5A, 1'b0, 2};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0000, 2, 16'h7777, 16'h0A5A, 1'b0, 2};

        // Reset state, sampled while reset is still asserted.
        #2;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        chk("rst_resp_rdata", {16'b0, resp_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of BUSY drops the access with no response.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1111; req_wdata = 16'h2222;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midbusy_mem_en", {31'b0, mem_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midbusy_rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("midbusy_rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("midbusy_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midbusy_rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midbusy_release_ready", {31'b0, req_ready}, 32'd1);
        chk("midbusy_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("midbusy_no_mem_en", {31'b0, mem_en}, 32'd0);
        model_rdata = 16'h0000;

        // Table-driven directed accesses.
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].k, vecs[i].mrd, got_d, got_e, got_n);
            chk($sformatf("vec%0d_rdata", i), {16'b0, got_d}, {16'b0, vecs[i].exp_rdata});
            chk($sformatf("vec%0d_err", i), {31'b0, got_e}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_en_cycles", i), got_n, vecs[i].exp_en);
        end
        model_rdata = 16'h0A5A;

        // req_valid held high, zero-wait memory, address changing every cycle.
        begin
            int          last_acc = -10;
            logic [15:0] acc_addr = '0;
            req_valid = 1'b1;
            req_we    = 1'b1;
            mem_ack   = 1'b1;
            for (int t = 0; t < 15; t++) begin
                if (mem_en) chk("held_mem_addr", {16'b0, mem_addr}, {16'b0, acc_addr});
                if (req_ready) begin
                    if (last_acc >= 0) chk("held_spacing", t - last_acc, 3);
                    last_acc = t;
                    acc_addr = req_addr;
                end
                @(negedge clk);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
            mem_ack = 1'b0;
            @(negedge clk);
            chk("held_idle_ready", {31'b0, req_ready}, 32'd1);
            chk("held_write_keeps_rdata", {16'b0, resp_rdata}, {16'b0, model_rdata});
        end

`ifdef PUNC_MEM_TIMEOUT_EN
        // No ack: BUSY for TO cycles, then an error response with zero data.
        access(1'b0, 16'h5000, 16'h0000, 1000, 16'h0000, got_d, got_e, got_n);
        chk("to_en_cycles", got_n, TO);
        chk("to_err", {31'b0, got_e}, 32'd1);
        chk("to_rdata", {16'b0, got_d}, 32'd0);
        // Ack on the limit cycle wins over the timeout.
        access(1'b0, 16'h5001, 16'h0000, TO, 16'h5678, got_d, got_e, got_n);
        chk("limit_ack_err", {31'b0, got_e}, 32'd0);
        chk("limit_ack_rdata", {16'b0, got_d}, 32'h5678);
        chk("limit_ack_en_cycles", got_n, TO);
        model_rdata = 16'h5678;
`endif

        // Randomized accesses against the model: reads return the memory word,
        // writes leave the previous response data in place, latency equals k.
        for (int r = 0; r < 40; r++) begin
            logic        we;
            logic [15:0] a, wd, md;
            int          k;
            we = 1'($urandom);
            a  = 16'($urandom);
            wd = 16'($urandom);
            md = 16'($urandom);
            k  = int'($urandom_range(1, TO));
            access(we, a, wd, k, md, got_d, got_e, got_n);
            if (!we) model_rdata = md;
            chk("rand_rdata", {16'b0, got_d}, {16'b0, model_rdata});
            chk("rand_err", {31'b0, got_e}, 32'd0);
            chk("rand_en_cycles", got_n, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
